// File: rtl/mux_rr_n.sv
// Purpose: N-channel registered mux with per-channel valid/ready; the source is picked by sel (MODE=0) or round-robin (MODE=1).
// Latency: 1 cycle from input handshake to out_valid; sustains 1 word/cycle, and a draining word is replaced on the same edge.
// Backpressure: while out_valid & !out_ready the output holds and every in_ready is 0; out_ready reaches in_ready combinationally.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_data/in_valid      channel i word at in_data[i*WIDTH +: WIDTH], qualified by in_valid[i]
//   in_ready              one-hot (or zero) accept strobe back to the granted channel
//   sel                   channel index in MODE=0, ignored in MODE=1
//   out_data/out_chan     registered word and its source channel index
//   out_valid/out_ready   output handshake
module mux_rr_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int CW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [CW-1:0]        sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    ptr_q, ptr_d;

  logic [N-1:0]     grant;
  logic [CW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             load;
  logic             xfer;

  // Output register can take a word when it is empty or draining this cycle.
  // Gating with rst_n keeps in_ready quiet while reset is held.
  assign load     = (!out_valid_q || out_ready) && rst_n;
  assign in_ready = grant & {N{load}};
  assign xfer     = gnt_any && load;

  // Grant selection. In round-robin mode the scan starts at ptr and wraps at
  // N (not 2^CW), so a non-power-of-two N never yields an index >= N.
  always_comb begin
    int            idx;
    logic [CW-1:0] idx_c;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_c   = '0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) begin
          grant[sel] = 1'b1;
          gnt_idx    = sel;
          gnt_any    = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        idx_c = CW'(idx);
        if (!gnt_any && in_valid[idx_c]) begin
          grant[idx_c] = 1'b1;
          gnt_idx      = idx_c;
          gnt_any      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      if (MODE != 0) begin
        ptr_d = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + CW'(1);
      end
    end else if (out_ready) begin
      // Drained with nothing to replace it: data/chan keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Selection is either an external select (MODE=0) or a built-in round-robin arbiter (MODE=1).
- The output is a one-entry pipeline register that tags each word with its source channel.
- Sits between multiple producers and one downstream consumer; replaces combinational 2:1 select where sources need flow control.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- N, 4, number of input channels (2..16).
- MODE, 0, 0 = external select via sel; 1 = round-robin arbitration (sel ignored).
- CW, $clog2(N), channel index width (derived; localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has a word.
- in_ready  output  N  channel i word accepted this cycle.
- sel  input  CW  channel index in MODE=0; unused in MODE=1.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  CW  source channel index of out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_chan=0; round-robin pointer ptr=0.
  - in_ready is combinationally 0 while out_valid=0 and no channel is valid.
- load = !out_valid | out_ready (output register empty or draining this cycle).
- Grant (combinational, one-hot or zero):
  - MODE=0: grant[sel] = in_valid[sel]. If sel >= N, no grant.
  - MODE=1: first i with in_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[i] = grant[i] & load. At most one in_ready bit is high per cycle.
- Transfer on the rising edge where some in_ready[i]=1:
  - out_data <= in_data[i]; out_chan <= i; out_valid <= 1.
  - Latency is 1 cycle from input handshake to out_valid.
- Output handshake:
  - If out_valid & out_ready and no new grant, out_valid <= 0 and out_data/out_chan hold their values.
  - If out_valid & out_ready and a grant occurs in the same cycle, the new word replaces the old one with no bubble.
  - Full throughput is 1 word/cycle.
- Stall: while out_valid & !out_ready, out_data/out_chan/out_valid hold and all in_ready=0.
- ptr update (MODE=1 only), on each accepted transfer from channel i: ptr <= (i==N-1) ? 0 : i+1. Unchanged when there is no transfer.
- MODE=1 fairness: a continuously valid channel is granted within N transfers.
- MODE=0: sel may change every cycle; it is sampled only in the cycle of transfer. A non-selected valid channel sees in_ready=0.
- Non-power-of-two N: ptr wraps at N, never to N..2^CW-1. out_chan is always < N.
- Reset mid-operation: any held word is discarded and ptr returns to 0. There is no in_ready pulse during reset.
- No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.

Test Plan:
- Reset: rst_n=0 asserted mid-stream with out_valid=1 -> out_valid, out_data and out_chan read 0 immediately, asynchronously; after release, first transfer with all in_valid=1 in MODE=1 is from ch0.
- MODE=0, N=4, WIDTH=8, sel=2:
  - in_data ch2=8'hA5 valid, ch0=8'h11 valid -> in_ready=4'b0100.
  - Next cycle out_data=8'hA5, out_chan=2, out_valid=1; ch0 never acked.
- MODE=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; out_valid high every cycle after the first.
- MODE=1, only ch1 and ch3 valid, ptr=2 -> first grant ch3, then ch1, then ch3; ch0 and ch2 in_ready stay 0.
- Backpressure:
  - Hold word 8'h3C, drop out_ready for 5 cycles -> out_data stays 3C and in_ready=0 all cycles.
  - Raise out_ready with ch0 valid -> same edge loads ch0, no bubble.
- N=3, MODE=1, sel=3 driven (ignored) -> grants wrap 0,1,2,0 and out_chan never equals 3. In MODE=0 with sel=3 -> no in_ready and out_valid falls after drain.
